// File: rtl/ex_stage_mdu.sv
// Execute stage with operand forwarding, ALU, branch-target adder, an
// iterative shift-add multiplier feeding HI/LO, and the EX/MEM register.
// The multiplier holds the front end via ex_stall while it iterates and
// retires its instruction on the edge that writes HI/LO.
module ex_stage_mdu #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic          flush,
  input  logic [1:0]    wb_ctlout,
  input  logic [2:0]    m_ctlout,
  input  logic [3:0]    ex_ctlout,
  input  logic [DW-1:0] npcout,
  input  logic [DW-1:0] rdata1out,
  input  logic [DW-1:0] rdata2out,
  input  logic [DW-1:0] s_extendout,
  input  logic [RW-1:0] instrout_2016,
  input  logic [RW-1:0] instrout_1511,
  input  logic [1:0]    fwd_a_sel,
  input  logic [1:0]    fwd_b_sel,
  input  logic [DW-1:0] mem_fwd_data,
  input  logic [DW-1:0] wb_fwd_data,
  output logic          ex_stall,
  output logic          EX_MEM_valid,
  output logic [1:0]    EX_MEM_wb_ctlout,
  output logic [2:0]    EX_MEM_m_ctlout,
  output logic [DW-1:0] EX_MEM_add_result,
  output logic          EX_MEM_zero,
  output logic [DW-1:0] EX_MEM_alu_result,
  output logic [DW-1:0] EX_MEM_rdata2out,
  output logic [RW-1:0] EX_MEM_five_bit_muxout
);

  // cnt must be able to hold DW-1
  localparam int CW = $clog2(DW) + 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  // Magnitude of a two's-complement operand; the most negative value maps
  // to 2^(DW-1), which fits as an unsigned DW-bit number.
  function automatic logic [DW-1:0] magnitude(input logic signed [DW-1:0] v);
    return v[DW-1] ? -v : v;
  endfunction

  logic [DW-1:0]   op_a, fwd_b, op_b, alu_res;
  logic [1:0]      alu_op;
  logic [5:0]      funct;
  logic            is_mul, mul_signed;
  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   hi, lo, mplier;
  logic [2*DW-1:0] acc, mcand, step_sum, product;
  logic            neg;
  logic            mul_start, mul_done, load;

  assign alu_op     = ex_ctlout[2:1];
  assign funct      = s_extendout[5:0];
  assign is_mul     = (alu_op == 2'b10) && (funct == 6'b011000 || funct == 6'b011001);
  assign mul_signed = ~funct[0];

  // Forwarding muxes for both operands, then the immediate select for B
  always_comb begin
    case (fwd_a_sel)
      2'b01:   op_a = mem_fwd_data;
      2'b10:   op_a = wb_fwd_data;
      default: op_a = rdata1out;
    endcase
    case (fwd_b_sel)
      2'b01:   fwd_b = mem_fwd_data;
      2'b10:   fwd_b = wb_fwd_data;
      default: fwd_b = rdata2out;
    endcase
    op_b = ex_ctlout[0] ? s_extendout : fwd_b;
  end

  // One shift-add step, and the sign-corrected product as it would be
  // after this step (only meaningful on the final step)
  assign step_sum = acc + (mplier[0] ? mcand : '0);
  assign product  = neg ? -step_sum : step_sum;

  // ALU decode; MULT/MULTU pass the low product word, which is only
  // retired on the completing step
  always_comb begin
    alu_res = op_a + op_b;
    case (alu_op)
      2'b01: alu_res = op_a - op_b;
      2'b11: alu_res = op_a | op_b;
      2'b10: begin
        case (funct)
          6'b100010: alu_res = op_a - op_b;
          6'b100100: alu_res = op_a & op_b;
          6'b100101: alu_res = op_a | op_b;
          6'b101010: alu_res = ($signed(op_a) < $signed(op_b)) ? DW'(1) : '0;
          6'b011000,
          6'b011001: alu_res = product[DW-1:0];
          6'b010000: alu_res = hi;
          6'b010010: alu_res = lo;
          default:   alu_res = op_a + op_b;
        endcase
      end
      default: alu_res = op_a + op_b;
    endcase
  end

  // Multiplier FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Multiplier FSM next-state logic; flush always aborts back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mul_start) state_nxt = BUSY;
      BUSY:    if (flush || cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Multiplier FSM outputs: start, completion and the front-end stall
  always_comb begin
    mul_start = (state == IDLE) && id_valid && is_mul && !flush;
    mul_done  = (state == BUSY) && (cnt == LAST) && !flush;
    ex_stall  = mul_start || ((state == BUSY) && (cnt != LAST));
  end

  // Step counter and HI/LO architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      if (mul_start)            cnt <= '0;
      else if (state == BUSY)   cnt <= cnt + CW'(1);
      if (mul_done) {hi, lo} <= product;
    end
  end

  // Multiplier operand and accumulator datapath
  always_ff @(posedge clk) begin
    if (mul_start) begin
      mcand  <= {{DW{1'b0}}, (mul_signed ? magnitude(op_a) : op_a)};
      mplier <= mul_signed ? magnitude(op_b) : op_b;
      neg    <= mul_signed && (op_a[DW-1] ^ op_b[DW-1]);
      acc    <= '0;
    end else if (state == BUSY) begin
      acc    <= step_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign load = !(ex_stall || flush || !id_valid);

  // EX/MEM register: bubbles clear valid and control but hold data fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      EX_MEM_valid           <= 1'b0;
      EX_MEM_wb_ctlout       <= '0;
      EX_MEM_m_ctlout        <= '0;
      EX_MEM_add_result      <= '0;
      EX_MEM_zero            <= 1'b0;
      EX_MEM_alu_result      <= '0;
      EX_MEM_rdata2out       <= '0;
      EX_MEM_five_bit_muxout <= '0;
    end else begin
      EX_MEM_valid     <= load;
      EX_MEM_wb_ctlout <= load ? wb_ctlout : 2'b00;
      EX_MEM_m_ctlout  <= load ? m_ctlout : 3'b000;
      if (load) begin
        EX_MEM_add_result      <= npcout + (s_extendout << 2);
        EX_MEM_zero            <= (alu_res == '0);
        EX_MEM_alu_result      <= alu_res;
        EX_MEM_rdata2out       <= fwd_b;
        EX_MEM_five_bit_muxout <= ex_ctlout[3] ? instrout_1511 : instrout_2016;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for ex_stage_mdu: ALU ops, forwarding, MULT/MULTU timing
// and results, flush and asynchronous reset behaviour.
module tb_ex_stage_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, flush;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic [3:0]  ex_ctlout;
  logic [31:0] npcout, rdata1out, rdata2out, s_extendout;
  logic [4:0]  instrout_2016, instrout_1511;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        ex_stall, EX_MEM_valid, EX_MEM_zero;
  logic [1:0]  EX_MEM_wb_ctlout;
  logic [2:0]  EX_MEM_m_ctlout;
  logic [31:0] EX_MEM_add_result, EX_MEM_alu_result, EX_MEM_rdata2out;
  logic [4:0]  EX_MEM_five_bit_muxout;

  int checks = 0;
  int errors = 0;
  int n;

  ex_stage_mdu #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .flush(flush),
    .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .ex_ctlout(ex_ctlout),
    .npcout(npcout), .rdata1out(rdata1out), .rdata2out(rdata2out),
    .s_extendout(s_extendout), .instrout_2016(instrout_2016),
    .instrout_1511(instrout_1511), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .ex_stall(ex_stall), .EX_MEM_valid(EX_MEM_valid),
    .EX_MEM_wb_ctlout(EX_MEM_wb_ctlout), .EX_MEM_m_ctlout(EX_MEM_m_ctlout),
    .EX_MEM_add_result(EX_MEM_add_result), .EX_MEM_zero(EX_MEM_zero),
    .EX_MEM_alu_result(EX_MEM_alu_result), .EX_MEM_rdata2out(EX_MEM_rdata2out),
    .EX_MEM_five_bit_muxout(EX_MEM_five_bit_muxout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // R-type instruction, RegDst=1, operands from the register file
  task automatic rtype(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    id_valid    = 1'b1;
    ex_ctlout   = 4'b1100;
    s_extendout = {26'd0, f};
    rdata1out   = a;
    rdata2out   = b;
    fwd_a_sel   = 2'b00;
    fwd_b_sel   = 2'b00;
  endtask

  // Present a multiply and count cycles with ex_stall high (bounded)
  task automatic run_mul(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int cycles);
    rtype(f, a, b);
    #1;
    cycles = 0;
    while (ex_stall && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0;
    wb_ctlout = 2'b11; m_ctlout = 3'b101; ex_ctlout = 4'b0000;
    npcout = 32'h0; rdata1out = 32'h0; rdata2out = 32'h0; s_extendout = 32'h0;
    instrout_2016 = 5'd8; instrout_1511 = 5'd3;
    fwd_a_sel = 2'b00; fwd_b_sel = 2'b00; mem_fwd_data = 32'h0; wb_fwd_data = 32'h0;

    #2;
    chk("reset_valid", EX_MEM_valid, 0);
    chk("reset_alu", EX_MEM_alu_result, 0);
    chk("reset_stall", ex_stall, 0);
    tick();
    rst_n = 1'b1;

    // ADD 5 + 7 -> rd 3
    rtype(6'b100000, 32'd5, 32'd7);
    #1 chk("add_stall", ex_stall, 0);
    tick();
    chk("add_result", EX_MEM_alu_result, 32'd12);
    chk("add_dest", EX_MEM_five_bit_muxout, 5'd3);
    chk("add_zero", EX_MEM_zero, 0);
    chk("add_valid", EX_MEM_valid, 1);
    chk("add_wb", EX_MEM_wb_ctlout, 2'b11);
    chk("add_m", EX_MEM_m_ctlout, 3'b101);

    // SUB via ALUOp 01, A forwarded from MEM
    id_valid = 1'b1; ex_ctlout = 4'b1010; fwd_a_sel = 2'b01; fwd_b_sel = 2'b00;
    rdata1out = 32'h55; mem_fwd_data = 32'd9; rdata2out = 32'd9;
    npcout = 32'h100; s_extendout = 32'd4;
    tick();
    chk("sub_result", EX_MEM_alu_result, 0);
    chk("sub_zero", EX_MEM_zero, 1);
    chk("sub_branch", EX_MEM_add_result, 32'h110);

    // OR immediate (ALUOp 11), RegDst=0, B forwarded from WB as store data
    ex_ctlout = 4'b0111; fwd_a_sel = 2'b11; fwd_b_sel = 2'b10;
    rdata1out = 32'hF0; s_extendout = 32'h0F; rdata2out = 32'h1234; wb_fwd_data = 32'hABCD;
    tick();
    chk("ori_result", EX_MEM_alu_result, 32'hFF);
    chk("ori_dest", EX_MEM_five_bit_muxout, 5'd8);
    chk("ori_store", EX_MEM_rdata2out, 32'hABCD);

    // AND with B forwarded from WB
    rtype(6'b100100, 32'hFF0F, 32'h0);
    fwd_b_sel = 2'b10; wb_fwd_data = 32'h0FF0;
    tick();
    chk("and_result", EX_MEM_alu_result, 32'h0F00);

    // Bubble: valid/ctl clear, data held
    id_valid = 1'b0;
    tick();
    chk("bubble_valid", EX_MEM_valid, 0);
    chk("bubble_wb", EX_MEM_wb_ctlout, 0);
    chk("bubble_hold", EX_MEM_alu_result, 32'h0F00);

    // SLT -1 < 1 and 1 < -1
    rtype(6'b101010, 32'hFFFFFFFF, 32'd1);
    tick();
    chk("slt_true", EX_MEM_alu_result, 1);
    rtype(6'b101010, 32'd1, 32'hFFFFFFFF);
    tick();
    chk("slt_false", EX_MEM_alu_result, 0);

    // MULT -3 * 7
    run_mul(6'b011000, 32'hFFFFFFFD, 32'd7, n);
    chk("mult_stall_cycles", n, 32);
    chk("mult_not_yet", EX_MEM_valid, 0);
    tick();
    chk("mult_retire", EX_MEM_valid, 1);
    rtype(6'b010010, 32'h0, 32'h0);
    #1 chk("mflo_stall", ex_stall, 0);
    tick();
    chk("mult_lo", EX_MEM_alu_result, 32'hFFFFFFEB);
    rtype(6'b010000, 32'h0, 32'h0);
    tick();
    chk("mult_hi", EX_MEM_alu_result, 32'hFFFFFFFF);

    // MULT 6 * -2, back to back
    run_mul(6'b011000, 32'd6, 32'hFFFFFFFE, n);
    chk("mult2_stall_cycles", n, 32);
    tick();
    rtype(6'b010010, 32'h0, 32'h0);
    tick();
    chk("mult2_lo", EX_MEM_alu_result, 32'hFFFFFFF4);

    // MULTU 0xFFFFFFFF * 2
    run_mul(6'b011001, 32'hFFFFFFFF, 32'd2, n);
    chk("multu_stall_cycles", n, 32);
    tick();
    chk("multu_retire", EX_MEM_valid, 1);
    rtype(6'b010000, 32'h0, 32'h0);
    tick();
    chk("multu_hi", EX_MEM_alu_result, 32'd1);
    rtype(6'b010010, 32'h0, 32'h0);
    tick();
    chk("multu_lo", EX_MEM_alu_result, 32'hFFFFFFFE);

    // Flush during BUSY cycle 10
    rtype(6'b011000, 32'd5, 32'd6);
    tick();
    repeat (9) tick();
    flush = 1'b1;
    tick();
    chk("flush_valid", EX_MEM_valid, 0);
    flush = 1'b0;
    id_valid = 1'b0;
    #1 chk("flush_stall_drop", ex_stall, 0);
    rtype(6'b010000, 32'h0, 32'h0);
    #1 chk("flush_idle_stall", ex_stall, 0);
    tick();
    chk("flush_hi_kept", EX_MEM_alu_result, 32'd1);
    rtype(6'b010010, 32'h0, 32'h0);
    tick();
    chk("flush_lo_kept", EX_MEM_alu_result, 32'hFFFFFFFE);

    // Flush together with a multiply start
    rtype(6'b011000, 32'd5, 32'd6);
    flush = 1'b1;
    #1 chk("flushstart_stall", ex_stall, 0);
    tick();
    chk("flushstart_valid", EX_MEM_valid, 0);
    flush = 1'b0;
    id_valid = 1'b0;
    #1 chk("flushstart_idle", ex_stall, 0);

    // Asynchronous reset in the middle of a multiply
    run_mul(6'b011000, 32'd3, 32'd3, n);
    tick();
    rtype(6'b011000, 32'd5, 32'd6);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", EX_MEM_valid, 0);
    chk("rst_alu", EX_MEM_alu_result, 0);
    chk("rst_branch", EX_MEM_add_result, 0);
    chk("rst_store", EX_MEM_rdata2out, 0);
    chk("rst_dest", EX_MEM_five_bit_muxout, 0);
    chk("rst_stall_from_inputs", ex_stall, 1);
    id_valid = 1'b0;
    #1 chk("rst_stall_idle", ex_stall, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    rtype(6'b010000, 32'h0, 32'h0);
    tick();
    chk("rst_mfhi", EX_MEM_alu_result, 0);
    chk("rst_mfhi_zero", EX_MEM_zero, 1);
    rtype(6'b010010, 32'h0, 32'h0);
    tick();
    chk("rst_mflo", EX_MEM_alu_result, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage_mdu.md
# ex_stage_mdu

Parametrised execute stage for the 5-stage MIPS pipeline. It sits between ID/EX and MEM, and owns the EX/MEM pipeline register. Beyond the original EX stage it adds:
- operand forwarding muxes;
- an iterative multiply unit (MULT/MULTU) with HI/LO registers and MFHI/MFLO;
- a stall/flush handshake toward the front end;
- a valid bit in EX/MEM.

## Interface

Parameters:
- DW, 32, datapath width (≥8)
- RW, 5, register-index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID/EX holds a live instruction
- flush  in  1  kill the ID/EX instruction, including an in-progress multiply
- wb_ctlout  in  2  WB control
- m_ctlout  in  3  MEM control
- ex_ctlout  in  4  [3] RegDst, [2:1] ALUOp, [0] ALUSrc
- npcout  in  DW  PC+4
- rdata1out, rdata2out  in  DW  register-file operands
- s_extendout  in  DW  sign-extended immediate; [5:0] is funct
- instrout_2016, instrout_1511  in  RW  rt, rd
- fwd_a_sel, fwd_b_sel  in  2  00 regfile, 01 mem_fwd_data, 10 wb_fwd_data, 11 regfile
- mem_fwd_data, wb_fwd_data  in  DW  forwarded values
- ex_stall  out  1  hold PC, IF/ID and ID/EX this cycle
- EX_MEM_valid  out  1  EX/MEM holds a live instruction
- EX_MEM_wb_ctlout  out  2
- EX_MEM_m_ctlout  out  3
- EX_MEM_add_result  out  DW  branch target
- EX_MEM_zero  out  1
- EX_MEM_alu_result  out  DW
- EX_MEM_rdata2out  out  DW  forwarded B operand (store data)
- EX_MEM_five_bit_muxout  out  RW  destination register

## Operation

Operand selection:
- opA = fwd_a_sel mux.
- fwdB = fwd_b_sel mux.
- opB = ALUSrc ? s_extendout : fwdB.

ALU decode:
- ALUOp 00 → add; 01 → sub; 11 → or.
- ALUOp 10 → by funct:
  - 100000 add; 100010 sub; 100100 and; 100101 or
  - 101010 slt (signed, result 1/0)
  - 011000 MULT; 011001 MULTU
  - 010000 MFHI (result = HI); 010010 MFLO (result = LO)
  - any other funct → add
- All arithmetic is modulo 2^DW.
- zero = (ALU result == 0).
- add_result = npcout + (s_extendout << 2), truncated to DW.
- Destination = RegDst ? instrout_1511 : instrout_2016.

Multiply unit, 2-state FSM IDLE/BUSY:
- IDLE, id_valid & is_mul & !flush:
  - latch |opA| and |opB| (magnitudes for MULT, raw for MULTU) plus the result sign;
  - clear the 2·DW accumulator and cnt;
  - go to BUSY.
- BUSY performs one shift-add step per cycle and increments cnt.
- On the step where cnt == DW-1:
  - write {HI,LO} = signed-corrected product;
  - go to IDLE.
- flush in BUSY → IDLE on the next edge; HI/LO unchanged; nothing is retired.
- A non-multiply instruction never enters BUSY.

Stall:
- ex_stall = (IDLE & id_valid & is_mul & !flush) | (BUSY & cnt != DW-1).
- ex_stall is combinational.

EX/MEM register, loaded every edge:
- If (ex_stall | flush | !id_valid): load a bubble.
  - Bubble = valid 0, wb/m ctl 0.
  - Data fields keep their previous value.
- Otherwise: load all computed fields with valid = 1.
- A multiply therefore retires on the edge that completes it.

Reset (rst_n low), asynchronous, all values 0:
- all EX_MEM outputs;
- HI, LO;
- FSM = IDLE; cnt;
- ex_stall then evaluates from inputs only.

## Timing

- Non-multiply instruction: 1-cycle latency. ID/EX in cycle n, EX/MEM valid in cycle n+1. No stall.
- Multiply presented in cycle 0:
  - ex_stall is 1 in cycles 0..DW-1 (DW stall cycles) and 0 in cycle DW.
  - HI/LO update and EX/MEM valid at the edge ending cycle DW.
  - Total occupancy: DW+1 cycles.
- MFHI/MFLO in the cycle after the multiply retires sees the new HI/LO. No hazard is exposed.
- Back-to-back multiplies: the second one starts from IDLE in the cycle after the first retires.
- Simultaneous flush and multiply-start: the flush wins. No BUSY entry, no stall, bubble loaded.
- rst_n asserted mid-multiply: immediate abort to IDLE; HI/LO = 0.

## Test plan

- Reset, then ADD (ALUOp 10, funct 100000, rdata1 = 5, rdata2 = 7, RegDst = 1, rd = 3) → next cycle EX_MEM_alu_result = 12, five_bit_muxout = 3, zero = 0, valid = 1.
- SUB with fwd_a_sel = 01 (mem_fwd_data = 9) and rdata2 = 9, npcout = 0x100, imm = 4 → alu_result = 0, zero = 1, add_result = 0x110.
- MULT, opA = −3, opB = 7, DW = 32 → ex_stall high exactly 32 cycles. On retire: HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. Following MFLO → alu_result = 0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 2 → HI = 1, LO = 0xFFFFFFFE. SLT of −1 vs 1 → 1.
- Flush asserted in BUSY cycle 10 → FSM IDLE next edge, ex_stall drops, HI/LO unchanged, EX_MEM_valid stays 0.
- rst_n pulsed low mid-multiply → all outputs 0 asynchronously. A later MFHI returns 0.
